store_rmw_unit: RTL and testbench
=================================

// Module: store_rmw_unit
// PURPOSE
// Sequential store engine between the control unit and data memory. Runs word,
// halfword and byte stores (SW/SH/SB) as a read-modify-write: it reads the word,
// merges the new lane into it and writes it back. Successor to the combinational
// store merge: data width is parametrised, the lane comes from the address, memory
// waits are handshaked, and misaligned stores and memory timeouts are reported.
// PARAMETERS
// DATA_W    32   data/memory word width in bits; multiple of 16, >=32
// ADDR_W    32   byte-address width
// WAIT_MAX  15   max cycles to wait for mem_ready per access before timeout (>=1)
// PORTS
// clk          in   1          rising-edge clock
// reset        in   1          asynchronous, active-low reset
// start        in   1          store request; sampled only in IDLE
// ss_mode      in   2          [1]=byte, else [0]=half, else word; [1] has priority
// addr         in   ADDR_W     byte address of store
// store_data   in   DATA_W     source register (B); lane taken from LSBs
// mem_rdata    in   DATA_W     memory read data, valid when mem_ready in RD_WAIT
// mem_ready    in   1          memory completion strobe (read data valid / write done)
// mem_addr     out  ADDR_W     word-aligned address (lane bits forced to 0)
// mem_rd       out  1          read request, held until mem_ready
// mem_wr       out  1          write request, held until mem_ready
// mem_wdata    out  DATA_W     merged write word, stable while mem_wr=1
// busy         out  1          1 in any state except IDLE
// done         out  1          1-cycle pulse when the store ends (ok or error)
// err_align    out  1          1-cycle pulse with done: misaligned store, no write
// err_timeout  out  1          1-cycle pulse with done: mem_ready missed, aborted
// BEHAVIOUR
// - Reset (reset=0, async): state=IDLE; all outputs 0; wait counter 0; latches 0.
// - LB = log2(DATA_W/8) lane bits; off = addr[LB-1:0]; little-endian lanes.
// - IDLE: on start=1, latch addr/store_data/ss_mode and check alignment:
//   half needs off[0]=0; word needs off=0. Byte is always aligned.
//   Misaligned -> DONE with err_align. Word -> WR_REQ (no read). Else -> RD_REQ.
// - RD_REQ/RD_WAIT: mem_rd=1 and mem_addr are driven from the cycle after start is
//   accepted. On mem_ready, capture mem_rdata -> WR_REQ.
// - Merge (registered on entry to WR_REQ): byte -> replace bits [8*off +: 8]
//   with store_data[7:0]; half -> replace [8*off +: 16] with store_data[15:0];
//   word -> store_data. All other bits come from the captured read word.
// - WR_REQ/WR_WAIT: mem_wr=1 with mem_wdata. On mem_ready -> DONE.
// - Wait counter: cleared when a request starts; +1 each cycle without mem_ready.
//   If the count reaches WAIT_MAX, drop mem_rd/mem_wr -> DONE with err_timeout.
//   mem_ready on that same cycle wins (success).
// - DONE: done=1 for one cycle (plus an error flag if set) -> IDLE. start is
//   ignored in DONE and accepted again in IDLE next cycle.
// - Minimum latency, start to done: word 3 cycles, byte/half 5 cycles (with
//   mem_ready on the first cycle of each access); misaligned 2 cycles.
// - mem_rd and mem_wr are never 1 together. start while busy is ignored (no queue).
// - mem_ready outside RD_WAIT/WR_WAIT is ignored.
// - Reset during an access aborts it at once: mem_wr drops, no done pulse.
// TESTING
// SB addr=0x1003, data=0xAB, mem_rdata=0x11223344 -> mem_addr=0x1000,
//   mem_wdata=0xAB223344, done after 5 cycles, no error flags.
// SH addr=0x2002, data=0xBEEF, rdata=0xCAFE0000 -> one read then write 0xBEEF0000.
// SW addr=0x3000, data=0xDEADBEEF -> no mem_rd ever, write 0xDEADBEEF, 3-cycle latency.
// SH addr=0x01, SW addr=0x02 -> done with err_align, mem_rd/mem_wr stay 0.
// SB with mem_ready held low -> mem_rd drops after WAIT_MAX cycles, err_timeout=1.
// Drop reset mid-WR_WAIT -> mem_wr=0 and busy=0 at once; then a new SB completes.

Source files
------------

// File: rtl/store_rmw_unit.sv
// ---------------------------------------------------------------------------
// store_rmw_unit
//
// Sequential store engine sitting between the control unit and data memory.
// Word stores (SW) are written directly. Halfword and byte stores (SH/SB) are
// done as read-modify-write: read the containing word, replace the addressed
// lane(s) with the low bits of the source register, then write the word back.
// Misaligned requests are rejected without touching memory. A memory access
// that does not see mem_ready in time is abandoned and reported.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   start        store request, sampled only while idle
//   ss_mode      [1]=byte, else [0]=half, else word ([1] has priority)
//   addr         byte address of the store
//   store_data   source register; the stored lane comes from its LSBs
//   mem_rdata    memory read data, valid with mem_ready during a read wait
//   mem_ready    memory completion strobe (read data valid / write done)
//   mem_addr     word-aligned memory address (lane bits forced to zero)
//   mem_rd       read request, held until mem_ready or timeout
//   mem_wr       write request, held until mem_ready or timeout
//   mem_wdata    merged write word, stable while mem_wr is high
//   busy         high in every state except idle
//   done         one-cycle pulse when a store ends (success or error)
//   err_align    one-cycle pulse with done: misaligned store, nothing written
//   err_timeout  one-cycle pulse with done: mem_ready missed, access aborted
// ---------------------------------------------------------------------------
module store_rmw_unit #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        ss_mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_align,
  output logic              err_timeout
);

  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int CW = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RD_REQ    = 3'd1,
    S_RD_WAIT   = 3'd2,
    S_WR_REQ    = 3'd3,
    S_WR_WAIT   = 3'd4,
    S_ALIGN_ERR = 3'd5,
    S_DONE      = 3'd6
  } state_e;

  state_e            state_q;
  logic              byte_q;
  logic [LB-1:0]     off_q;
  logic [15:0]       data_q;
  logic [CW-1:0]     wait_cnt_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_rd_q;
  logic              mem_wr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              busy_q;
  logic              done_q;
  logic              err_align_q;
  logic              err_timeout_q;

  logic              req_byte_s;
  logic              req_half_s;
  logic              req_word_s;
  logic              aligned_s;
  logic              wait_expired_s;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] merge_d;
  logic [CW-1:0]     wait_cnt_d;

  // Replace the addressed byte (or the byte pair for a halfword) of the word
  // just read; every other lane keeps the value read from memory.
  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [DATA_W-1:0] old_word,
    input logic [15:0]       src,
    input logic [LB-1:0]     off,
    input logic              is_byte
  );
    logic [DATA_W-1:0] res;
    logic [LB-1:0]     off_hi;
    res    = old_word;
    off_hi = off + LB'(1);
    for (int i = 0; i < NB; i++) begin
      if (LB'(i) == off) begin
        res[8*i +: 8] = src[7:0];
      end else if (!is_byte && (LB'(i) == off_hi)) begin
        res[8*i +: 8] = src[15:8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

  // Request decode, alignment check, merged write word and wait-count step.
  always_comb begin
    req_byte_s = ss_mode[1];
    req_half_s = ~ss_mode[1] & ss_mode[0];
    req_word_s = ~ss_mode[1] & ~ss_mode[0];
    if (req_byte_s) begin
      aligned_s = 1'b1;
    end else if (req_half_s) begin
      aligned_s = ~addr[0];
    end else begin
      aligned_s = (addr[LB-1:0] == {LB{1'b0}});
    end
    mem_addr_d     = {addr[ADDR_W-1:LB], {LB{1'b0}}};
    merge_d        = merge_lanes(mem_rdata, data_q, off_q, byte_q);
    wait_cnt_d     = wait_cnt_q + CW'(1);
    // The access is abandoned on the cycle the missed-ready count hits WAIT_MAX.
    wait_expired_s = (wait_cnt_d == CW'(WAIT_MAX));
  end

  // Store sequencer; all memory-side and status outputs are registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      byte_q        <= 1'b0;
      off_q         <= {LB{1'b0}};
      data_q        <= 16'h0000;
      wait_cnt_q    <= {CW{1'b0}};
      mem_addr_q    <= {ADDR_W{1'b0}};
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_wdata_q   <= {DATA_W{1'b0}};
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_align_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q        <= 1'b0;
          err_align_q   <= 1'b0;
          err_timeout_q <= 1'b0;
          if (start) begin
            byte_q     <= req_byte_s;
            off_q      <= addr[LB-1:0];
            data_q     <= store_data[15:0];
            mem_addr_q <= mem_addr_d;
            wait_cnt_q <= {CW{1'b0}};
            busy_q     <= 1'b1;
            if (!aligned_s) begin
              state_q <= S_ALIGN_ERR;
            end else if (req_word_s) begin
              // A full word needs no read; the write word is the source as-is.
              mem_wdata_q <= store_data;
              mem_wr_q    <= 1'b1;
              state_q     <= S_WR_REQ;
            end else begin
              mem_rd_q <= 1'b1;
              state_q  <= S_RD_REQ;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end

        // First request cycle: mem_ready is not looked at yet.
        S_RD_REQ: begin
          state_q <= S_RD_WAIT;
        end

        S_RD_WAIT: begin
          if (mem_ready) begin
            // Read and write requests swap on the same edge, never overlapping.
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b1;
            mem_wdata_q <= merge_d;
            wait_cnt_q  <= {CW{1'b0}};
            state_q     <= S_WR_REQ;
          end else if (wait_expired_s) begin
            mem_rd_q      <= 1'b0;
            wait_cnt_q    <= wait_cnt_d;
            done_q        <= 1'b1;
            err_timeout_q <= 1'b1;
            state_q       <= S_DONE;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end

        S_WR_REQ: begin
          state_q <= S_WR_WAIT;
        end

        S_WR_WAIT: begin
          if (mem_ready) begin
            mem_wr_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else if (wait_expired_s) begin
            mem_wr_q      <= 1'b0;
            wait_cnt_q    <= wait_cnt_d;
            done_q        <= 1'b1;
            err_timeout_q <= 1'b1;
            state_q       <= S_DONE;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end

        // Misaligned stores spend one busy cycle here so the error completion
        // has a fixed two-cycle latency and never drives the memory port.
        S_ALIGN_ERR: begin
          done_q      <= 1'b1;
          err_align_q <= 1'b1;
          state_q     <= S_DONE;
        end

        // done and any error flag are high for exactly this cycle.
        S_DONE: begin
          done_q        <= 1'b0;
          err_align_q   <= 1'b0;
          err_timeout_q <= 1'b0;
          busy_q        <= 1'b0;
          state_q       <= S_IDLE;
        end

        default: begin
          mem_rd_q      <= 1'b0;
          mem_wr_q      <= 1'b0;
          busy_q        <= 1'b0;
          done_q        <= 1'b0;
          err_align_q   <= 1'b0;
          err_timeout_q <= 1'b0;
          state_q       <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_rd      = mem_rd_q;
  assign mem_wr      = mem_wr_q;
  assign mem_wdata   = mem_wdata_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_align   = err_align_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_store_rmw_unit.sv
// ---------------------------------------------------------------------------
// tb_store_rmw_unit
//
// Directed bench for store_rmw_unit. A small memory responder raises
// mem_ready a programmable number of cycles after a request appears and
// records what the DUT drove on the memory port; each directed store is then
// compared against hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_store_rmw_unit;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int WAIT_MAX = 15;

  logic              clk;
  logic              reset;
  logic              start;
  logic [1:0]        ss_mode;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] store_data;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic              busy;
  logic              done;
  logic              err_align;
  logic              err_timeout;

  int n_cmp;
  int n_bad;

  // responder settings and observations
  int          rd_delay;
  int          wr_delay;
  int          age;
  bit          prev_rd;
  bit          prev_wr;
  int          rd_cnt;
  int          wr_cnt;
  int          both_cnt;
  logic [31:0] wdata_seen;
  logic [31:0] waddr_seen;
  logic [31:0] raddr_seen;

  store_rmw_unit #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .WAIT_MAX(WAIT_MAX)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ss_mode    (ss_mode),
    .addr       (addr),
    .store_data (store_data),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .err_align  (err_align),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory responder: ready comes on request-age delay+1 (age 1 = request cycle).
  initial begin
    mem_ready = 1'b0;
    age       = 0;
    prev_rd   = 1'b0;
    prev_wr   = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_rd && mem_wr) both_cnt++;
      if (mem_rd) begin
        rd_cnt++;
        raddr_seen = mem_addr;
      end
      if (mem_wr) begin
        wr_cnt++;
        wdata_seen = mem_wdata;
        waddr_seen = mem_addr;
      end
      if ((mem_rd && !prev_rd) || (mem_wr && !prev_wr)) age = 1;
      else if (mem_rd || mem_wr) age++;
      else age = 0;
      mem_ready = (mem_rd && (age == rd_delay + 1)) || (mem_wr && (age == wr_delay + 1));
      prev_rd = mem_rd;
      prev_wr = mem_wr;
    end
  end

  task automatic clear_obs();
    rd_cnt     = 0;
    wr_cnt     = 0;
    both_cnt   = 0;
    wdata_seen = 32'h0;
    waddr_seen = 32'h0;
    raddr_seen = 32'h0;
  endtask

  task automatic run_store(
    input string       name,
    input logic [1:0]  mode,
    input logic [31:0] a,
    input logic [31:0] d,
    input logic [31:0] rdata,
    input int          rdly,
    input int          wdly,
    input bit          hold,
    input int          exp_lat,
    input int          exp_rd,
    input int          exp_wr,
    input logic [31:0] exp_addr,
    input logic [31:0] exp_wdata,
    input logic        exp_ea,
    input logic        exp_et
  );
    int n;
    @(negedge clk);
    #1;
    rd_delay = rdly;
    wr_delay = wdly;
    clear_obs();
    ss_mode    = mode;
    addr       = a;
    store_data = d;
    mem_rdata  = rdata;
    start      = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (!hold) start = 1'b0;
    end while (!done && n < 60);
    start = 1'b0;
    check_eq({name, ".latency"}, n, exp_lat);
    check_eq({name, ".err_align"}, err_align, exp_ea);
    check_eq({name, ".err_timeout"}, err_timeout, exp_et);
    @(posedge clk);
    #1;
    check_eq({name, ".done_busy_after"}, {done, busy}, 2'b00);
    check_eq({name, ".rd_cycles"}, rd_cnt, exp_rd);
    check_eq({name, ".wr_cycles"}, wr_cnt, exp_wr);
    check_eq({name, ".rd_wr_overlap"}, both_cnt, 0);
    if (exp_rd > 0) check_eq({name, ".rd_addr"}, raddr_seen, exp_addr);
    if (exp_wr > 0) begin
      check_eq({name, ".wr_addr"}, waddr_seen, exp_addr);
      check_eq({name, ".wdata"}, wdata_seen, exp_wdata);
    end
  endtask

  initial begin
    int n;
    int pulses;
    n_cmp      = 0;
    n_bad      = 0;
    rd_delay   = 1;
    wr_delay   = 1;
    clear_obs();
    start      = 1'b0;
    ss_mode    = 2'b00;
    addr       = 32'h0;
    store_data = 32'h0;
    mem_rdata  = 32'h0;
    reset      = 1'b1;
    #1 reset = 1'b0;
    #2;
    check_eq("reset.mem_addr", mem_addr, 32'h0);
    check_eq("reset.mem_wdata", mem_wdata, 32'h0);
    check_eq("reset.rd_wr", {mem_rd, mem_wr}, 2'b00);
    check_eq("reset.status", {busy, done, err_align, err_timeout}, 4'b0000);
    @(negedge clk);
    reset = 1'b1;

    //        name    mode   addr          data          rdata         rd wr hold lat rd wr exp_addr      exp_wdata     ea    et
    run_store("sb",   2'b10, 32'h0000_1003, 32'h0000_00AB, 32'h1122_3344, 1, 1, 1'b0, 5, 2, 2, 32'h0000_1000, 32'hAB22_3344, 1'b0, 1'b0);
    run_store("sh",   2'b01, 32'h0000_2002, 32'h0000_BEEF, 32'hCAFE_0000, 1, 1, 1'b0, 5, 2, 2, 32'h0000_2000, 32'hBEEF_0000, 1'b0, 1'b0);
    run_store("sw",   2'b00, 32'h0000_3000, 32'hDEAD_BEEF, 32'h5555_5555, 1, 1, 1'b0, 3, 0, 2, 32'h0000_3000, 32'hDEAD_BEEF, 1'b0, 1'b0);
    run_store("sh_mis", 2'b01, 32'h0000_0001, 32'h0000_1111, 32'h0,       1, 1, 1'b0, 2, 0, 0, 32'h0,         32'h0,         1'b1, 1'b0);
    run_store("sw_mis", 2'b00, 32'h0000_0002, 32'h2222_2222, 32'h0,       1, 1, 1'b0, 2, 0, 0, 32'h0,         32'h0,         1'b1, 1'b0);
    // mode 11 must be a byte store: a halfword at offset 1 would be misaligned
    run_store("sb_m11", 2'b11, 32'h0000_4001, 32'h1234_565A, 32'hFFFF_FFFF, 1, 1, 1'b0, 5, 2, 2, 32'h0000_4000, 32'hFFFF_5AFF, 1'b0, 1'b0);
    // start held high through the whole store must not start a second one
    run_store("sh_hold", 2'b01, 32'h0000_4000, 32'h7777_1234, 32'hAAAA_AAAA, 1, 1, 1'b1, 5, 2, 2, 32'h0000_4000, 32'hAAAA_1234, 1'b0, 1'b0);
    // read never answered: RD_REQ plus WAIT_MAX wait cycles, then abort
    run_store("sb_tmo", 2'b10, 32'h0000_6002, 32'h0000_0099, 32'h0,        200, 1, 1'b0, WAIT_MAX + 2, WAIT_MAX + 1, 0, 32'h0000_6000, 32'h0, 1'b0, 1'b1);
    // write answered on the last permitted wait cycle still succeeds
    run_store("sw_last", 2'b00, 32'h0000_7004, 32'h0BAD_F00D, 32'h0,      1, WAIT_MAX, 1'b0, WAIT_MAX + 2, 0, WAIT_MAX + 1, 32'h0000_7004, 32'h0BAD_F00D, 1'b0, 1'b0);

    // reset in the middle of a write wait
    @(negedge clk);
    #1;
    rd_delay   = 1;
    wr_delay   = 200;
    clear_obs();
    ss_mode    = 2'b10;
    addr       = 32'h0000_5001;
    store_data = 32'h0000_0011;
    mem_rdata  = 32'h0;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (!mem_wr && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("rst.reach_wr", mem_wr, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_eq("rst.mem_wr", mem_wr, 1'b0);
    check_eq("rst.busy", busy, 1'b0);
    check_eq("rst.done", done, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done || busy) pulses++;
    end
    check_eq("rst.quiet_after", pulses, 0);

    run_store("sb_after_rst", 2'b10, 32'h0000_5002, 32'h0000_00C3, 32'h0102_0304, 1, 1, 1'b0, 5, 2, 2, 32'h0000_5000, 32'h01C3_0304, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
